mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Pipeline, SRAM and UART signals of the memory arbiter, bundled as one interface.
// The slave modport is the arbiter's view; master is the pipeline/memory side.
interface mem_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_data;
  logic        if_valid;

  logic        mem_req;
  logic        mem_op;
  logic [17:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        pause;

  logic [17:0] sram_addr;
  logic [15:0] sram_wdata;
  logic        sram_wr_drive;
  logic [15:0] sram_rdata;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  logic        data_ready;
  logic        tbre;
  logic        tsre;
  logic        rdn;
  logic        wrn;

  modport slave (
    input  if_req, if_addr, mem_req, mem_op, mem_addr, mem_wdata,
    input  sram_rdata, data_ready, tbre, tsre,
    output if_data, if_valid, mem_rdata, mem_done, pause,
    output sram_addr, sram_wdata, sram_wr_drive, sram_ce_n, sram_oe_n, sram_we_n,
    output rdn, wrn
  );

  modport master (
    output if_req, if_addr, mem_req, mem_op, mem_addr, mem_wdata,
    output sram_rdata, data_ready, tbre, tsre,
    input  if_data, if_valid, mem_rdata, mem_done, pause,
    input  sram_addr, sram_wdata, sram_wr_drive, sram_ce_n, sram_oe_n, sram_we_n,
    input  rdn, wrn
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data access onto one SRAM and a memory-mapped UART.
// Strobes are registered from the next-state decode so they line up with the state.
module mem_arbiter (
  input  logic          clk_50MHz,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 2;

  localparam logic [SW-1:0] IDLE      = 4'd0;
  localparam logic [SW-1:0] IF_RD     = 4'd1;
  localparam logic [SW-1:0] MEM_RD    = 4'd2;
  localparam logic [SW-1:0] MEM_WR1   = 4'd3;
  localparam logic [SW-1:0] MEM_WR2   = 4'd4;
  localparam logic [SW-1:0] UART_RD   = 4'd5;
  localparam logic [SW-1:0] UART_WR   = 4'd6;
  localparam logic [SW-1:0] UART_WAIT = 4'd7;
  localparam logic [SW-1:0] DONE      = 4'd8;

  localparam logic [AW-1:0] UART_DATA_ADDR = 18'h0BF00;
  localparam logic [AW-1:0] UART_STAT_ADDR = 18'h0BF01;

  logic [SW-1:0] state, n_state;
  logic [CW-1:0] rd_cnt, n_rd_cnt;
  logic          is_stat, is_udata, stat_rd;
  logic          n_ce_n, n_oe_n, n_we_n, n_wr_drive, n_rdn, n_wrn;

  assign is_stat  = (bus.mem_addr == UART_STAT_ADDR);
  assign is_udata = (bus.mem_addr == UART_DATA_ADDR);
  assign stat_rd  = (state == IDLE) && bus.mem_req && is_stat && !bus.mem_op;

  // Stall while a data request is outstanding or any data access is in flight.
  assign bus.pause = (bus.mem_req && (state != DONE)) ||
                     !((state == IDLE) || (state == IF_RD) || (state == DONE));

  // Next-state logic; rd_cnt counts the two rdn-low cycles of a UART read.
  always_comb begin
    n_state  = state;
    n_rd_cnt = '0;
    case (state)
      IDLE: begin
        if (bus.mem_req) begin
          if (is_stat)       n_state = DONE;
          else if (is_udata) n_state = bus.mem_op ? UART_WR : UART_RD;
          else               n_state = bus.mem_op ? MEM_WR1 : MEM_RD;
        end else if (bus.if_req) begin
          n_state = IF_RD;
        end
      end
      IF_RD:   n_state = IDLE;
      MEM_RD:  n_state = DONE;
      MEM_WR1: n_state = MEM_WR2;
      MEM_WR2: n_state = DONE;
      UART_RD: begin
        if (rd_cnt == CW'(2))                         n_state = DONE;
        else if (rd_cnt == CW'(1) || bus.data_ready)  n_rd_cnt = rd_cnt + CW'(1);
        else                                          n_rd_cnt = rd_cnt;
      end
      UART_WR:   n_state = UART_WAIT;
      UART_WAIT: if (bus.tbre && bus.tsre) n_state = DONE;
      DONE:      n_state = IDLE;
      default:   n_state = IDLE;
    endcase
  end

  // Strobe values for the cycle about to start.
  always_comb begin
    n_ce_n     = 1'b1;
    n_oe_n     = 1'b1;
    n_we_n     = 1'b1;
    n_wr_drive = 1'b0;
    n_rdn      = 1'b1;
    n_wrn      = 1'b1;
    case (n_state)
      IF_RD, MEM_RD: begin
        n_ce_n = 1'b0;
        n_oe_n = 1'b0;
      end
      MEM_WR1: begin
        n_ce_n     = 1'b0;
        n_wr_drive = 1'b1;
      end
      MEM_WR2: begin
        n_ce_n     = 1'b0;
        n_we_n     = 1'b0;
        n_wr_drive = 1'b1;
      end
      UART_WR: begin
        n_wrn      = 1'b0;
        n_wr_drive = 1'b1;
      end
      UART_RD: n_rdn = (n_rd_cnt == CW'(0));
      default: ;
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state             <= IDLE;
      rd_cnt            <= '0;
      bus.if_data       <= '0;
      bus.if_valid      <= 1'b0;
      bus.mem_rdata     <= '0;
      bus.mem_done      <= 1'b0;
      bus.sram_addr     <= '0;
      bus.sram_wdata    <= '0;
      bus.sram_wr_drive <= 1'b0;
      bus.sram_ce_n     <= 1'b1;
      bus.sram_oe_n     <= 1'b1;
      bus.sram_we_n     <= 1'b1;
      bus.rdn           <= 1'b1;
      bus.wrn           <= 1'b1;
    end else begin
      state             <= n_state;
      rd_cnt            <= n_rd_cnt;
      bus.sram_ce_n     <= n_ce_n;
      bus.sram_oe_n     <= n_oe_n;
      bus.sram_we_n     <= n_we_n;
      bus.sram_wr_drive <= n_wr_drive;
      bus.rdn           <= n_rdn;
      bus.wrn           <= n_wrn;
      bus.if_valid      <= (state == IF_RD);
      bus.mem_done      <= (n_state == DONE);

      if (state == IF_RD) bus.if_data <= bus.sram_rdata;

      if ((state == MEM_RD) || ((state == UART_RD) && (rd_cnt == CW'(2))))
        bus.mem_rdata <= bus.sram_rdata;
      else if (stat_rd)
        bus.mem_rdata <= {{(DW-2){1'b0}}, bus.data_ready, bus.tbre & bus.tsre};

      // Latch address/data when a request is accepted so they stay stable.
      if (state == IDLE) begin
        if (bus.mem_req) begin
          bus.sram_addr  <= bus.mem_addr;
          bus.sram_wdata <= bus.mem_wdata;
        end else if (bus.if_req) begin
          bus.sram_addr  <= {2'b00, bus.if_addr};
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a transaction-level model.
module tb_mem_arbiter;
  logic clk_50MHz = 1'b0;
  logic rst;
  always #10 clk_50MHz = ~clk_50MHz;

  mem_arbiter_if bus();
  mem_arbiter dut (.clk_50MHz(clk_50MHz), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: what is in flight, how old it is, when it completes.
  localparam int K_NONE = 0, K_FETCH = 1, K_SRD = 2, K_SWR = 3;
  localparam int K_URD = 4, K_UWR = 5, K_STAT = 6;
  int          mk = K_NONE, ma = 0, mdone_at = -1, mtrig = -1;
  logic [17:0] maddr = '0;
  logic [15:0] mwdata = '0, mrd = '0, faddr = '0, fdata = '0;
  logic        mread = 1'b0, fv = 1'b0, served = 1'b0, model_on = 1'b0;

  task automatic model_step();
    logic fv_n;
    fv_n   = 1'b0;
    served = 1'b0;
    if (rst) begin
      mk = K_NONE;
      model_on = 1'b1;
    end else if (mk == K_FETCH) begin
      fv_n  = 1'b1;
      fdata = bus.sram_rdata;
      mk    = K_NONE;
    end else if (mk != K_NONE) begin
      if (mk == K_SRD && ma == 1) mrd = bus.sram_rdata;
      if (mk == K_URD && mtrig >= 0 && ma == mtrig + 2) mrd = bus.sram_rdata;
      if (mk == K_URD && mtrig < 0 && bus.data_ready) begin
        mtrig = ma;
        mdone_at = ma + 3;
      end
      if (mk == K_UWR && ma >= 2 && mdone_at < 0 && bus.tbre && bus.tsre) mdone_at = ma + 1;
      if (ma == mdone_at) begin
        mk = K_NONE;
        served = 1'b1;
      end else begin
        ma++;
      end
    end else if (bus.mem_req) begin
      ma = 1; mtrig = -1;
      maddr = bus.mem_addr; mwdata = bus.mem_wdata; mread = !bus.mem_op;
      if (maddr == 18'h0BF01) begin
        mk = K_STAT; mdone_at = 1;
        if (!bus.mem_op) mrd = {14'b0, bus.data_ready, bus.tbre & bus.tsre};
      end else if (maddr == 18'h0BF00) begin
        mk = bus.mem_op ? K_UWR : K_URD; mdone_at = -1;
      end else begin
        mk = bus.mem_op ? K_SWR : K_SRD; mdone_at = bus.mem_op ? 3 : 2;
      end
    end else if (bus.if_req) begin
      mk = K_FETCH; ma = 1; faddr = bus.if_addr;
    end
    fv = fv_n;
  endtask

  task automatic compare();
    logic memk, e_done, e_ce, e_oe, e_we, e_drv, e_wrn, e_rdn, e_pause;
    logic [17:0] e_addr;
    memk    = (mk >= K_SRD);
    e_done  = memk && (ma == mdone_at);
    e_ce    = !((mk == K_FETCH) || (mk == K_SRD && ma == 1) || (mk == K_SWR && ma <= 2));
    e_oe    = !((mk == K_FETCH) || (mk == K_SRD && ma == 1));
    e_we    = !(mk == K_SWR && ma == 2);
    e_drv   = (mk == K_SWR && ma <= 2) || (mk == K_UWR && ma == 1);
    e_wrn   = !(mk == K_UWR && ma == 1);
    e_rdn   = !(mk == K_URD && mtrig >= 0 && ma > mtrig && ma <= mtrig + 2);
    e_pause = memk ? (ma != mdone_at) : bus.mem_req;
    e_addr  = (mk == K_FETCH) ? {2'b00, faddr} : maddr;
    chk("mem_done", 32'(bus.mem_done), 32'(e_done));
    chk("if_valid", 32'(bus.if_valid), 32'(fv));
    chk("ce_n", 32'(bus.sram_ce_n), 32'(e_ce));
    chk("oe_n", 32'(bus.sram_oe_n), 32'(e_oe));
    chk("we_n", 32'(bus.sram_we_n), 32'(e_we));
    chk("wr_drive", 32'(bus.sram_wr_drive), 32'(e_drv));
    chk("wrn", 32'(bus.wrn), 32'(e_wrn));
    chk("rdn", 32'(bus.rdn), 32'(e_rdn));
    chk("pause", 32'(bus.pause), 32'(e_pause));
    if (!e_ce) chk("sram_addr", 32'(bus.sram_addr), 32'(e_addr));
    if (e_drv) chk("sram_wdata", 32'(bus.sram_wdata), 32'(mwdata));
    if (fv) chk("if_data", 32'(bus.if_data), 32'(fdata));
    if (e_done && mread) chk("mem_rdata", 32'(bus.mem_rdata), 32'(mrd));
  endtask

  initial forever begin
    @(posedge clk_50MHz);
    model_step();
  end

  initial forever begin
    @(negedge clk_50MHz);
    if (model_on) compare();
  end

  task automatic nxt();
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic neg();
    @(negedge clk_50MHz);
  endtask

  task automatic quiet();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_req = 1'b0; bus.mem_op = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
    bus.sram_rdata = '0; bus.data_ready = 1'b0; bus.tbre = 1'b0; bus.tsre = 1'b0;
  endtask

  int cnt_low, done_c, val_c;

  initial begin
    rst = 1'b1;
    quiet();
    nxt(); nxt();
    neg();
    chk("rst_ce_n", 32'(bus.sram_ce_n), 32'd1);
    chk("rst_we_n", 32'(bus.sram_we_n), 32'd1);
    chk("rst_rdn_wrn", 32'({bus.rdn, bus.wrn}), 32'd3);
    chk("rst_wr_drive", 32'(bus.sram_wr_drive), 32'd0);
    chk("rst_valids", 32'({bus.if_valid, bus.mem_done}), 32'd0);
    chk("rst_data", 32'({bus.if_data, bus.mem_rdata}), 32'd0);
    nxt();
    rst = 1'b0;

    // Fetch
    bus.if_req = 1'b1; bus.if_addr = 16'h0010; bus.sram_rdata = 16'h4A21;
    neg(); chk("fetch_pause_c0", 32'(bus.pause), 32'd0);
    nxt(); bus.if_req = 1'b0;
    neg();
    chk("fetch_ce_oe_c1", 32'({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}), 32'd1);
    chk("fetch_addr_c1", 32'(bus.sram_addr), 32'h10);
    chk("fetch_pause_c1", 32'(bus.pause), 32'd0);
    nxt(); neg();
    chk("fetch_valid_c2", 32'(bus.if_valid), 32'd1);
    chk("fetch_data_c2", 32'(bus.if_data), 32'h4A21);
    chk("fetch_pause_c2", 32'(bus.pause), 32'd0);
    nxt(); neg(); chk("fetch_valid_c3", 32'(bus.if_valid), 32'd0);
    nxt();

    // Data write
    bus.mem_req = 1'b1; bus.mem_op = 1'b1; bus.mem_addr = 18'h08000; bus.mem_wdata = 16'hBEEF;
    cnt_low = 0;
    for (int c = 0; c < 5; c++) begin
      neg();
      if (!bus.sram_we_n) cnt_low++;
      chk("wr_done", 32'(bus.mem_done), 32'(c == 3));
      chk("wr_pause", 32'(bus.pause), 32'(c <= 2));
      if (c == 2) begin
        chk("wr_we_c2", 32'(bus.sram_we_n), 32'd0);
        chk("wr_addr_c2", 32'(bus.sram_addr), 32'h08000);
        chk("wr_data_c2", 32'(bus.sram_wdata), 32'hBEEF);
      end
      nxt();
      if (c == 3) bus.mem_req = 1'b0;
    end
    chk("wr_we_low_cycles", 32'(cnt_low), 32'd1);

    // Collision: data read wins, fetch follows
    bus.if_req = 1'b1; bus.if_addr = 16'h0077;
    bus.mem_req = 1'b1; bus.mem_op = 1'b0; bus.mem_addr = 18'h00020; bus.sram_rdata = 16'h1234;
    done_c = -1; val_c = -1;
    for (int c = 0; c < 8; c++) begin
      neg();
      if (bus.mem_done && done_c < 0) done_c = c;
      if (bus.if_valid && val_c < 0) val_c = c;
      if (c == 2) chk("col_rdata", 32'(bus.mem_rdata), 32'h1234);
      nxt();
      if (c == 2) bus.mem_req = 1'b0;
      if (c == 4) bus.if_req = 1'b0;
    end
    chk("col_done_cycle", 32'(done_c), 32'd2);
    chk("col_valid_cycle", 32'(val_c), 32'd5);

    // UART status read
    bus.mem_req = 1'b1; bus.mem_op = 1'b0; bus.mem_addr = 18'h0BF01;
    bus.data_ready = 1'b1; bus.tbre = 1'b1; bus.tsre = 1'b0;
    neg(); chk("stat_pause_c0", 32'(bus.pause), 32'd1);
    nxt(); neg();
    chk("stat_done_c1", 32'(bus.mem_done), 32'd1);
    chk("stat_rdata_c1", 32'(bus.mem_rdata), 32'h0002);
    chk("stat_pause_c1", 32'(bus.pause), 32'd0);
    nxt(); bus.mem_req = 1'b0; bus.data_ready = 1'b0; bus.tbre = 1'b0;
    neg(); chk("stat_done_c2", 32'(bus.mem_done), 32'd0);
    nxt();

    // UART write with slow transmitter
    bus.mem_req = 1'b1; bus.mem_op = 1'b1; bus.mem_addr = 18'h0BF00; bus.mem_wdata = 16'h0041;
    cnt_low = 0;
    for (int c = 0; c < 12; c++) begin
      bus.tbre = (c >= 5); bus.tsre = (c >= 8);
      neg();
      if (!bus.wrn) cnt_low++;
      chk("uwr_done", 32'(bus.mem_done), 32'(c == 9));
      chk("uwr_pause", 32'(bus.pause), 32'(c <= 8));
      chk("uwr_sram_off", 32'({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}), 32'd7);
      if (c == 1) begin
        chk("uwr_drive_c1", 32'(bus.sram_wr_drive), 32'd1);
        chk("uwr_data_c1", 32'(bus.sram_wdata), 32'h0041);
      end
      nxt();
      if (c == 9) bus.mem_req = 1'b0;
    end
    chk("uwr_wrn_low_cycles", 32'(cnt_low), 32'd1);

    // Reset during MEM_WR2, then a fetch in the first cycle out of reset
    bus.mem_req = 1'b1; bus.mem_op = 1'b1; bus.mem_addr = 18'h01234; bus.mem_wdata = 16'h5A5A;
    nxt(); nxt();
    rst = 1'b1;
    neg(); chk("rmo_we_wr2", 32'(bus.sram_we_n), 32'd0);
    nxt();
    rst = 1'b0; bus.mem_req = 1'b0; bus.if_req = 1'b1; bus.if_addr = 16'h0042;
    neg();
    chk("rmo_we_after", 32'(bus.sram_we_n), 32'd1);
    chk("rmo_done_after", 32'(bus.mem_done), 32'd0);
    chk("rmo_data_cleared", 32'({bus.if_data, bus.mem_rdata}), 32'd0);
    nxt(); bus.if_req = 1'b0;
    neg();
    chk("rmo_done_next", 32'(bus.mem_done), 32'd0);
    chk("rmo_fetch_ce", 32'(bus.sram_ce_n), 32'd0);
    chk("rmo_fetch_addr", 32'(bus.sram_addr), 32'h42);
    nxt(); neg(); chk("rmo_fetch_valid", 32'(bus.if_valid), 32'd1);
    nxt();

    // Randomized traffic; a data request is held until the model says it completed
    for (int i = 0; i < 1500; i++) begin
      if (!(bus.mem_req && !served)) begin
        bus.mem_req   = ($urandom_range(0, 2) == 0);
        bus.mem_op    = 1'($urandom_range(0, 1));
        bus.mem_wdata = 16'($urandom);
        case ($urandom_range(0, 3))
          0: bus.mem_addr = 18'h0BF01;
          1: bus.mem_addr = 18'h0BF00;
          default: bus.mem_addr = 18'($urandom);
        endcase
      end
      bus.if_req     = 1'($urandom_range(0, 1));
      bus.if_addr    = 16'($urandom);
      bus.sram_rdata = 16'($urandom);
      bus.data_ready = ($urandom_range(0, 3) == 0);
      bus.tbre       = 1'($urandom_range(0, 1));
      bus.tsre       = 1'($urandom_range(0, 1));
      nxt();
    end

    quiet();
    nxt(); nxt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
